// File: rtl/core_msg_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : core_msg_receiver
//  Description : Core-side receiver of the scheduler message bus. Decodes the
//                activity and R0-select masks for this core, latches one-shot
//                R0 values, and buffers this core's instructions in a FIFO
//                that is drained by the execution unit over valid/take.
//                Optional macro CORE_RX_ERR_EN enables the sticky proto_err
//                and overflow flags; without it both are tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_msg_receiver #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] END_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  core_id,
  input  logic        val_ins,
  input  logic        val_mask_ac,
  input  logic        val_mask_R0,
  input  logic        val_R0,
  input  logic [15:0] instruction,
  input  logic        instr_take,
  input  logic        exec_done,
  output logic        ready,
  output logic        active,
  output logic        instr_valid,
  output logic [15:0] instr_out,
  output logic [15:0] r0_value,
  output logic        r0_loaded,
  output logic        finished,
  output logic        proto_err,
  output logic        overflow
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    rst_sync;
  logic          rst_n;

  logic          mask_bit;
  logic          sel_ac, sel_mr0, sel_r0, sel_ins;
  logic          accepting, can_accept, push, pop, is_end;

  logic          r0_sel;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // Reset synchroniser: assertion is immediate, release aligned to clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Strobe priority: only the highest-priority message is consumed
  assign mask_bit = instruction[core_id];
  assign sel_ac   = val_mask_ac;
  assign sel_mr0  = val_mask_R0 & ~val_mask_ac;
  assign sel_r0   = val_R0 & ~val_mask_ac & ~val_mask_R0;
  assign sel_ins  = val_ins & ~val_mask_ac & ~val_mask_R0 & ~val_R0;

  // A full FIFO still accepts a word when the head is popped in the same cycle
  assign pop        = instr_take && (count != '0);
  assign can_accept = (count != DEPTH_C) || pop;
  assign accepting  = sel_ins && active && (state == ST_RUN);
  assign push       = accepting && can_accept;
  assign is_end     = (instruction[15:12] == END_OPCODE);

  // Mask decode and one-shot R0 capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      r0_sel    <= 1'b0;
      r0_value  <= 16'h0000;
      r0_loaded <= 1'b0;
    end else if (sel_ac) begin
      active <= mask_bit;
    end else if (sel_mr0) begin
      r0_sel <= mask_bit;
    end else if (sel_r0 && r0_sel) begin
      r0_value  <= instruction;
      r0_loaded <= 1'b1;
      r0_sel    <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care until pointed at by a valid entry
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= instruction;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign instr_valid = (count != '0);
  assign instr_out   = instr_valid ? mem[rd_ptr] : 16'h0000;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state and state-derived outputs
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    finished = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_ac && mask_bit) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (push && is_end)
          state_nx = ST_DRAIN;
        else if (!active && (count == '0) && !(sel_ac && mask_bit))
          state_nx = ST_IDLE;
      end
      ST_DRAIN: begin
        if ((count == '0) && exec_done) state_nx = ST_DONE;
      end
      ST_DONE: begin
        finished = 1'b1;
        if (sel_ac) state_nx = mask_bit ? ST_RUN : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    ready = (state != ST_DRAIN) && (count < DEPTH_C);
  end

`ifdef CORE_RX_ERR_EN
  logic multi;
  logic drop;
  logic perr_q, ovf_q;

  assign multi = (val_mask_ac & val_mask_R0) | (val_mask_ac & val_R0) |
                 (val_mask_ac & val_ins)     | (val_mask_R0 & val_R0) |
                 (val_mask_R0 & val_ins)     | (val_R0 & val_ins);
  assign drop  = accepting && !can_accept;

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (multi || (sel_ins && (state == ST_DRAIN))) perr_q <= 1'b1;
      if (drop)                                      ovf_q  <= 1'b1;
    end
  end

  assign proto_err = perr_q;
  assign overflow  = ovf_q;
`else
  assign proto_err = 1'b0;
  assign overflow  = 1'b0;
`endif

endmodule
`default_nettype wire
